wb_commit_unit: RTL and testbench
=================================

# wb_commit_unit

Parametrised write-back stage for the pipelined CPU datapath. Accepts retiring instructions from MEM over a valid/ready handshake and supports variable-latency data-memory load responses, with a load wait state machine. Extracts and sign/zero-extends the loaded bytes or halves for XLEN of 32 or 64, and drives a registered register-file write port that also serves as the WB forwarding source. Adds flush handling, stale-response draining and a load timeout with a sticky error flag.

## Interface
- `XLEN`, 32: datapath width; legal values are 32 and 64.
- `REG_AW`, 5: register address width.
- `TIMEOUT`, 64: maximum cycles spent in WAIT or DRAIN before abort; must be ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: MEM presents an instruction.
- `in_ready` out 1: stage accepts; transfer when `in_valid & in_ready`.
- `in_ctrl` in `wb_ctrl_t`: fields `reg_write`, `mem_to_reg`, `size[1:0]`, `load_signed`.
- `in_rw` in REG_AW: destination register.
- `in_exout` in XLEN: ALU result, or load address when `mem_to_reg`.
- `dm_rvalid` in 1: data-memory response strobe.
- `dm_rdata` in XLEN: raw aligned memory word.
- `flush` in 1: kill the incoming instruction and any pending load.
- `rf_we` out 1: register-file write enable; registered.
- `rf_wa` out REG_AW: write address; registered.
- `rf_wd` out XLEN: write data; registered.
- `busy` out 1: high when the state is not IDLE.
- `timeout_err` out 1: sticky error flag; cleared only by `rst`.

## Operation
- States:
  - IDLE: accepting.
  - WAIT: load pending.
  - DRAIN: flushed load; discard its response.
- `in_ready = (state==IDLE) & !flush & !rst`.
- Accept in IDLE, non-load (`mem_to_reg=0`): the next edge sets `rf_we = reg_write & (in_rw!=0)`, `rf_wa = in_rw`, `rf_wd = in_exout`.
- Accept in IDLE, load:
  - If `dm_rvalid` is high in the same cycle, commit extended data at the next edge; state stays IDLE.
  - Otherwise latch ctrl, `rw` and address, then go to WAIT with the counter at 0.
- WAIT:
  - `dm_rvalid` high: commit extended data at the next edge, go to IDLE.
  - `flush` high with `dm_rvalid` low: go to DRAIN, no write.
  - `flush` and `dm_rvalid` in the same cycle: the data is discarded, go to IDLE.
- DRAIN: `dm_rvalid` high goes to IDLE with no write.
- `dm_rvalid` in IDLE without a same-cycle load accept is ignored.
- Timeout:
  - The counter increments each cycle in WAIT or DRAIN.
  - When it reaches TIMEOUT-1 and `dm_rvalid` is low: go to IDLE, set `timeout_err`, no write.
- `rf_we` deasserts in every cycle that has no commit (single-cycle pulse per instruction).
- `flush` never cancels an `rf_we` already registered.
- Load extension: `off = addr[$clog2(XLEN/8)-1:0]`, rounded down to the access size.
  - `size`: 00 = byte, 01 = half, 10 = word, 11 = dword.
  - dword is legal only when XLEN=64; when XLEN=32 it is treated as word.
  - Selected lanes are `dm_rdata[off*8 +: bits]`.
  - The result is sign-extended if `load_signed`, else zero-extended; XLEN-wide loads pass through unchanged.
- A write to `rw==0` is always suppressed.

## Timing
- Commit latency:
  - Non-load: 1 cycle after accept.
  - Load: 1 cycle after the `dm_rvalid` cycle.
- Throughput: 1 non-load per cycle; a load blocks acceptance until its response or timeout.
- Reset (asynchronous) values:
  - `rf_we=0`, `rf_wa=0`, `rf_wd=0`, `timeout_err=0`, `busy=0`.
  - State IDLE, counter 0.
  - `in_ready=0` while `rst` is high.
- Reset asserted mid-WAIT abandons the load; a response arriving after reset release is ignored (state is IDLE).

## Structure
- `wb_pkg`:
  - `wb_size_e` (BYTE/HALF/WORD/DWORD).
  - `wb_state_e` (IDLE/WAIT/DRAIN).
  - `wb_ctrl_t` packed struct.
  - Localparam helper for the lane-offset width.
- Sub-module `wb_load_ext`: combinational; inputs XLEN, rdata, addr low bits, size, signed; output extended data.
- Top level holds the FSM, timeout counter, latched load context and output registers.

## Test plan
- Non-loads, XLEN=32: accept `rw=3, exout=0x1234` then `rw=0, exout=5` back-to-back → `rf_we=1, wa=3, wd=0x1234`, then `rf_we=0`.
- Signed byte load: `addr=0x1003`, `dm_rdata=0x80FF_7F01` after 3 waits → `busy` for 3 cycles, then `wd=0xFFFFFF80`; unsigned half at `addr=0x2` → `0x000080FF`.
- XLEN=64 dword and word loads:
  - Signed word at `addr=4` with `rdata=0x8000_0000_1111_1111` → `wd=0xFFFFFFFF80000000`.
  - Dword → raw data.
- Flush in WAIT then `dm_rvalid` 2 cycles later → no `rf_we`, DRAIN held until the response, `in_ready` returns the cycle after.
- No response for TIMEOUT=8 cycles → IDLE after 8 cycles, `timeout_err=1` sticky, no write; subsequent non-load commits normally.
- `rst` pulse during WAIT, then a late `dm_rvalid` → all outputs 0, response ignored, no write.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back/commit stage.
package wb_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } wb_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b10
  } wb_state_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_to_reg;
    wb_size_e size;
    logic     load_signed;
  } wb_ctrl_t;

  // Width of the byte-lane offset inside one XLEN-wide memory word.
  function automatic int lane_aw(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Load data extractor: picks the addressed byte/half/word lanes out of a raw
// memory word and sign- or zero-extends them to XLEN.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]          rdata,
  input  logic [lane_aw(XLEN)-1:0] addr_lo,
  input  wb_size_e                 size,
  input  logic                     load_signed,
  output logic [XLEN-1:0]          data
);

  localparam int OFF_W = lane_aw(XLEN);

  wb_size_e         eff_size;
  logic [OFF_W-1:0] low_mask;
  logic [OFF_W-1:0] off_al;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  keep;
  logic             msb;

  always_comb begin
    // A 32-bit datapath has no dword access; treat it as a full word.
    eff_size = (XLEN == 32 && size == DWORD) ? WORD : size;
    low_mask = '0;
    keep     = '1;
    case (eff_size)
      BYTE: begin
        keep = XLEN'(8'hFF);
      end
      HALF: begin
        low_mask = OFF_W'(1);
        keep     = XLEN'(16'hFFFF);
      end
      WORD: begin
        low_mask = OFF_W'(3);
        keep     = XLEN'(32'hFFFF_FFFF);
      end
      default: begin
        low_mask = OFF_W'(7);
      end
    endcase
    off_al  = addr_lo & ~low_mask;
    shifted = rdata >> {off_al, 3'b000};
    // Top bit of the kept field is the sign bit of the loaded value.
    msb     = |(shifted & keep & ~(keep >> 1));
    data    = (shifted & keep) | ({XLEN{load_signed & msb}} & ~keep);
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back stage: accepts retiring instructions, waits for load responses,
// and drives the registered register-file write port.
module wb_commit_unit
  import wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  wb_ctrl_t          in_ctrl,
  input  logic [REG_AW-1:0] in_rw,
  input  logic [XLEN-1:0]   in_exout,
  input  logic              dm_rvalid,
  input  logic [XLEN-1:0]   dm_rdata,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd,
  output logic              busy,
  output logic              timeout_err
);

  localparam int               OFF_W    = lane_aw(XLEN);
  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb_state_e         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ctx_we_reg, ctx_we_next;
  logic [REG_AW-1:0] ctx_rw_reg, ctx_rw_next;
  wb_size_e          ctx_size_reg, ctx_size_next;
  logic              ctx_signed_reg, ctx_signed_next;
  logic [OFF_W-1:0]  ctx_off_reg, ctx_off_next;
  logic              rf_we_reg, rf_we_next;
  logic [REG_AW-1:0] rf_wa_reg, rf_wa_next;
  logic [XLEN-1:0]   rf_wd_reg, rf_wd_next;
  logic              timeout_err_reg, timeout_err_next;

  logic              is_idle;
  logic              accept;
  logic              in_we;
  wb_size_e          ext_size;
  logic              ext_signed;
  logic [OFF_W-1:0]  ext_off;
  logic [XLEN-1:0]   ext_data;

  assign is_idle  = (state_reg == IDLE);
  assign in_ready = is_idle & ~flush & ~rst;
  assign accept   = in_valid & in_ready;
  assign in_we    = in_ctrl.reg_write & (in_rw != '0);

  // In IDLE the extender looks at the incoming load so a same-cycle response commits directly.
  assign ext_size   = is_idle ? in_ctrl.size               : ctx_size_reg;
  assign ext_signed = is_idle ? in_ctrl.load_signed        : ctx_signed_reg;
  assign ext_off    = is_idle ? in_exout[OFF_W-1:0]        : ctx_off_reg;

  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata       (dm_rdata),
    .addr_lo     (ext_off),
    .size        (ext_size),
    .load_signed (ext_signed),
    .data        (ext_data)
  );

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    ctx_we_next      = ctx_we_reg;
    ctx_rw_next      = ctx_rw_reg;
    ctx_size_next    = ctx_size_reg;
    ctx_signed_next  = ctx_signed_reg;
    ctx_off_next     = ctx_off_reg;
    rf_we_next       = 1'b0;
    rf_wa_next       = rf_wa_reg;
    rf_wd_next       = rf_wd_reg;
    timeout_err_next = timeout_err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!in_ctrl.mem_to_reg) begin
            rf_we_next = in_we;
            rf_wa_next = in_rw;
            rf_wd_next = in_exout;
          end else if (dm_rvalid) begin
            rf_we_next = in_we;
            rf_wa_next = in_rw;
            rf_wd_next = ext_data;
          end else begin
            ctx_we_next     = in_we;
            ctx_rw_next     = in_rw;
            ctx_size_next   = in_ctrl.size;
            ctx_signed_next = in_ctrl.load_signed;
            ctx_off_next    = in_exout[OFF_W-1:0];
            cnt_next        = '0;
            state_next      = WAIT;
          end
        end
      end
      WAIT: begin
        if (dm_rvalid) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (!flush) begin
            rf_we_next = ctx_we_reg;
            rf_wa_next = ctx_rw_reg;
            rf_wd_next = ext_data;
          end
        end else if (cnt_reg == CNT_LAST) begin
          state_next       = IDLE;
          cnt_next         = '0;
          timeout_err_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (flush) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (dm_rvalid) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next       = IDLE;
          cnt_next         = '0;
          timeout_err_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      ctx_we_reg      <= 1'b0;
      ctx_rw_reg      <= '0;
      ctx_size_reg    <= BYTE;
      ctx_signed_reg  <= 1'b0;
      ctx_off_reg     <= '0;
      rf_we_reg       <= 1'b0;
      rf_wa_reg       <= '0;
      rf_wd_reg       <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      ctx_we_reg      <= ctx_we_next;
      ctx_rw_reg      <= ctx_rw_next;
      ctx_size_reg    <= ctx_size_next;
      ctx_signed_reg  <= ctx_signed_next;
      ctx_off_reg     <= ctx_off_next;
      rf_we_reg       <= rf_we_next;
      rf_wa_reg       <= rf_wa_next;
      rf_wd_reg       <= rf_wd_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign rf_we       = rf_we_reg;
  assign rf_wa       = rf_wa_reg;
  assign rf_wd       = rf_wd_reg;
  assign busy        = !is_idle;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: one XLEN=32 and one XLEN=64 instance
// share stimulus; each scenario task checks its own expected values.
`timescale 1ns/1ps
module tb_wb_commit_unit;
  import wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        dm_rvalid;
  logic        flush;
  wb_ctrl_t    in_ctrl;
  logic [4:0]  in_rw;
  logic [63:0] in_exout;
  logic [63:0] dm_rdata;

  logic        in_ready32, rf_we32, busy32, err32;
  logic [4:0]  rf_wa32;
  logic [31:0] rf_wd32;
  logic        in_ready64, rf_we64, busy64, err64;
  logic [4:0]  rf_wa64;
  logic [63:0] rf_wd64;

  int checks = 0;
  int errors = 0;

  wb_commit_unit #(.XLEN(32), .REG_AW(5), .TIMEOUT(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_ctrl(in_ctrl), .in_rw(in_rw), .in_exout(in_exout[31:0]),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata[31:0]), .flush(flush),
    .rf_we(rf_we32), .rf_wa(rf_wa32), .rf_wd(rf_wd32),
    .busy(busy32), .timeout_err(err32)
  );

  wb_commit_unit #(.XLEN(64), .REG_AW(5), .TIMEOUT(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_ctrl(in_ctrl), .in_rw(in_rw), .in_exout(in_exout),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .flush(flush),
    .rf_we(rf_we64), .rf_wa(rf_wa64), .rf_wd(rf_wd64),
    .busy(busy64), .timeout_err(err64)
  );

  always #5 clk = ~clk;

  function automatic wb_ctrl_t mk(input logic w, input logic m, input wb_size_e s, input logic sg);
    wb_ctrl_t c;
    c.reg_write   = w;
    c.mem_to_reg  = m;
    c.size        = s;
    c.load_signed = sg;
    return c;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 0; dm_rvalid = 0; flush = 0;
    in_ctrl = '0; in_rw = '0; in_exout = '0; dm_rdata = '0;
    tick; tick;
    checks++;
    if ({rf_we32, rf_wa32, rf_wd32, busy32, err32} !== '0) begin
      errors++; $display("FAIL reset_out32: got %h want 0", {rf_we32, rf_wa32, rf_wd32, busy32, err32});
    end
    checks++;
    if ({in_ready32, in_ready64} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {in_ready32, in_ready64});
    end
    rst = 0;
    #1;
    checks++;
    if (in_ready32 !== 1'b1) begin
      errors++; $display("FAIL ready_after_rst: got %b want 1", in_ready32);
    end
    $display("reset done");
  endtask

  task automatic test_nonload;
    in_valid = 1; in_ctrl = mk(1, 0, WORD, 0); in_rw = 3; in_exout = 64'h1234;
    tick;
    checks++;
    if ({rf_we32, rf_wa32, rf_wd32} !== {1'b1, 5'd3, 32'h1234}) begin
      errors++; $display("FAIL nl_rw3: got %b/%0d/%h want 1/3/1234", rf_we32, rf_wa32, rf_wd32);
    end
    $display("txn nonload rw=3 wd=%h", rf_wd32);
    in_rw = 0; in_exout = 64'h5;
    tick;
    checks++;
    if ({rf_we32, rf_wd32} !== {1'b0, 32'h5}) begin
      errors++; $display("FAIL nl_rw0: got we=%b wd=%h want 0/5", rf_we32, rf_wd32);
    end
    $display("txn nonload rw=0 we=%b", rf_we32);
    in_ctrl = mk(0, 0, WORD, 0); in_rw = 7; in_exout = 64'h77;
    tick;
    checks++;
    if (rf_we32 !== 1'b0) begin
      errors++; $display("FAIL nl_nowrite: got %b want 0", rf_we32);
    end
    in_ctrl = mk(1, 0, WORD, 0); in_rw = 8; in_exout = 64'hAAAA;
    tick;
    checks++;
    if ({rf_we32, rf_wa32, rf_wd32} !== {1'b1, 5'd8, 32'hAAAA}) begin
      errors++; $display("FAIL nl_b2b_a: got %b/%0d/%h want 1/8/aaaa", rf_we32, rf_wa32, rf_wd32);
    end
    in_rw = 9; in_exout = 64'hBBBB;
    tick;
    checks++;
    if ({rf_we32, rf_wa32, rf_wd32} !== {1'b1, 5'd9, 32'hBBBB}) begin
      errors++; $display("FAIL nl_b2b_b: got %b/%0d/%h want 1/9/bbbb", rf_we32, rf_wa32, rf_wd32);
    end
    in_valid = 0;
    tick;
    checks++;
    if (rf_we32 !== 1'b0) begin
      errors++; $display("FAIL nl_pulse: got %b want 0", rf_we32);
    end
  endtask

  task automatic test_load32;
    in_valid = 1; in_ctrl = mk(1, 1, BYTE, 1); in_rw = 9; in_exout = 64'h1003;
    dm_rvalid = 0; dm_rdata = 64'h80FF_7F01;
    tick;
    in_valid = 0; in_exout = '0;
    #1;
    checks++;
    if ({busy32, rf_we32, in_ready32} !== 3'b100) begin
      errors++; $display("FAIL ld_wait0: got busy/we/rdy=%b want 100", {busy32, rf_we32, in_ready32});
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if ({busy32, rf_we32} !== 2'b10) begin
        errors++; $display("FAIL ld_wait%0d: got busy/we=%b want 10", i + 1, {busy32, rf_we32});
      end
    end
    dm_rvalid = 1;
    tick;
    dm_rvalid = 0;
    checks++;
    if ({busy32, rf_we32, rf_wa32, rf_wd32} !== {1'b0, 1'b1, 5'd9, 32'hFFFF_FF80}) begin
      errors++; $display("FAIL ld_sbyte: got busy=%b we=%b wa=%0d wd=%h want 0/1/9/ffffff80", busy32, rf_we32, rf_wa32, rf_wd32);
    end
    $display("txn load sbyte rw=9 wd=%h", rf_wd32);
    tick;
    checks++;
    if (rf_we32 !== 1'b0) begin
      errors++; $display("FAIL ld_pulse: got %b want 0", rf_we32);
    end
    in_valid = 1; dm_rvalid = 1; in_ctrl = mk(1, 1, HALF, 0); in_rw = 10; in_exout = 64'h2;
    tick;
    checks++;
    if ({busy32, rf_we32, rf_wa32, rf_wd32} !== {1'b0, 1'b1, 5'd10, 32'h0000_80FF}) begin
      errors++; $display("FAIL ld_uhalf: got busy=%b we=%b wa=%0d wd=%h want 0/1/10/000080ff", busy32, rf_we32, rf_wa32, rf_wd32);
    end
    $display("txn load uhalf rw=10 wd=%h", rf_wd32);
    in_ctrl = mk(1, 1, HALF, 1); in_rw = 11; in_exout = 64'h3;
    tick;
    checks++;
    if (rf_wd32 !== 32'hFFFF_80FF) begin
      errors++; $display("FAIL ld_shalf_round: got %h want ffff80ff", rf_wd32);
    end
    in_ctrl = mk(1, 1, DWORD, 1); in_rw = 12; in_exout = 64'h1001;
    tick;
    checks++;
    if (rf_wd32 !== 32'h80FF_7F01) begin
      errors++; $display("FAIL ld_dword32: got %h want 80ff7f01", rf_wd32);
    end
    in_valid = 0;
    tick;
    checks++;
    if ({rf_we32, busy32} !== 2'b00) begin
      errors++; $display("FAIL stray_rvalid: got we/busy=%b want 00", {rf_we32, busy32});
    end
    dm_rvalid = 0;
  endtask

  task automatic test_load64;
    dm_rdata = 64'h8000_0000_1111_1111; in_valid = 1; dm_rvalid = 1;
    in_ctrl = mk(1, 1, WORD, 1); in_rw = 13; in_exout = 64'h4;
    tick;
    checks++;
    if ({rf_we64, rf_wa64, rf_wd64} !== {1'b1, 5'd13, 64'hFFFF_FFFF_8000_0000}) begin
      errors++; $display("FAIL ld64_sword: got %b/%0d/%h want 1/13/ffffffff80000000", rf_we64, rf_wa64, rf_wd64);
    end
    $display("txn load64 sword rw=13 wd=%h", rf_wd64);
    in_ctrl = mk(1, 1, DWORD, 1); in_rw = 14; in_exout = 64'h0;
    tick;
    checks++;
    if (rf_wd64 !== 64'h8000_0000_1111_1111) begin
      errors++; $display("FAIL ld64_dword: got %h want 8000000011111111", rf_wd64);
    end
    in_ctrl = mk(1, 1, BYTE, 0); in_rw = 15; in_exout = 64'h7;
    tick;
    checks++;
    if (rf_wd64 !== 64'h80) begin
      errors++; $display("FAIL ld64_ubyte7: got %h want 80", rf_wd64);
    end
    in_ctrl = mk(1, 1, WORD, 1); in_rw = 17; in_exout = 64'h4; dm_rvalid = 0;
    tick;
    in_valid = 0; in_exout = '0; dm_rvalid = 1;
    tick;
    dm_rvalid = 0;
    checks++;
    if ({busy64, rf_we64, rf_wa64, rf_wd64} !== {1'b0, 1'b1, 5'd17, 64'hFFFF_FFFF_8000_0000}) begin
      errors++; $display("FAIL ld64_waited: got busy=%b we=%b wa=%0d wd=%h", busy64, rf_we64, rf_wa64, rf_wd64);
    end
    tick;
  endtask

  task automatic test_flush;
    dm_rdata = 64'h1234_5678; in_valid = 1; in_ctrl = mk(1, 1, WORD, 0); in_rw = 20; in_exout = '0;
    tick;
    in_valid = 0; flush = 1;
    #1;
    checks++;
    if (in_ready32 !== 1'b0) begin
      errors++; $display("FAIL fl_ready: got %b want 0", in_ready32);
    end
    tick;
    flush = 0;
    checks++;
    if ({busy32, rf_we32} !== 2'b10) begin
      errors++; $display("FAIL fl_drain0: got busy/we=%b want 10", {busy32, rf_we32});
    end
    tick;
    checks++;
    if ({busy32, rf_we32} !== 2'b10) begin
      errors++; $display("FAIL fl_drain1: got busy/we=%b want 10", {busy32, rf_we32});
    end
    dm_rvalid = 1;
    tick;
    dm_rvalid = 0;
    checks++;
    if ({busy32, rf_we32, in_ready32} !== 3'b001) begin
      errors++; $display("FAIL fl_release: got busy/we/rdy=%b want 001", {busy32, rf_we32, in_ready32});
    end
    $display("txn flushed load rw=20 discarded");
    in_valid = 1; in_rw = 21;
    tick;
    in_valid = 0; flush = 1; dm_rvalid = 1;
    tick;
    flush = 0; dm_rvalid = 0;
    checks++;
    if ({busy32, rf_we32} !== 2'b00) begin
      errors++; $display("FAIL fl_same_cycle: got busy/we=%b want 00", {busy32, rf_we32});
    end
    in_valid = 1; in_ctrl = mk(1, 0, WORD, 0); in_rw = 22; in_exout = 64'h22;
    tick;
    flush = 1;
    #1;
    checks++;
    if ({rf_we32, rf_wa32, in_ready32} !== {1'b1, 5'd22, 1'b0}) begin
      errors++; $display("FAIL fl_keep_we: got we=%b wa=%0d rdy=%b want 1/22/0", rf_we32, rf_wa32, in_ready32);
    end
    tick;
    flush = 0; in_valid = 0;
    checks++;
    if (rf_we32 !== 1'b0) begin
      errors++; $display("FAIL fl_kill_in: got %b want 0", rf_we32);
    end
  endtask

  task automatic test_timeout;
    in_valid = 1; in_ctrl = mk(1, 1, WORD, 0); in_rw = 23; in_exout = '0; dm_rvalid = 0;
    tick;
    in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({busy32, rf_we32, err32} !== 3'b100) begin
        errors++; $display("FAIL to_wait%0d: got busy/we/err=%b want 100", i, {busy32, rf_we32, err32});
      end
      tick;
    end
    checks++;
    if ({busy32, rf_we32, err32, err64} !== 4'b0011) begin
      errors++; $display("FAIL to_abort: got busy/we/err/err64=%b want 0011", {busy32, rf_we32, err32, err64});
    end
    $display("txn load rw=23 timed out");
    tick;
    checks++;
    if (err32 !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %b want 1", err32);
    end
    in_valid = 1; in_ctrl = mk(1, 0, WORD, 0); in_rw = 4; in_exout = 64'hABCD;
    tick;
    in_valid = 0;
    checks++;
    if ({rf_we32, rf_wa32, rf_wd32, err32} !== {1'b1, 5'd4, 32'hABCD, 1'b1}) begin
      errors++; $display("FAIL to_after: got we=%b wa=%0d wd=%h err=%b want 1/4/abcd/1", rf_we32, rf_wa32, rf_wd32, err32);
    end
  endtask

  task automatic test_reset_mid_wait;
    in_valid = 1; in_ctrl = mk(1, 1, WORD, 0); in_rw = 25; in_exout = '0;
    tick;
    in_valid = 0;
    tick;
    checks++;
    if (busy32 !== 1'b1) begin
      errors++; $display("FAIL rw_busy: got %b want 1", busy32);
    end
    rst = 1;
    #1;
    checks++;
    if ({rf_we32, rf_wa32, rf_wd32, busy32, err32, in_ready32, in_ready64, err64} !== '0) begin
      errors++; $display("FAIL rw_async: got %h want 0", {rf_we32, rf_wa32, rf_wd32, busy32, err32, in_ready32, in_ready64, err64});
    end
    tick;
    rst = 0; dm_rvalid = 1; dm_rdata = 64'hDEAD_BEEF;
    tick;
    dm_rvalid = 0;
    checks++;
    if ({rf_we32, rf_wd32, busy32, in_ready32} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rw_late_resp: got we=%b wd=%h busy=%b rdy=%b want 0/0/0/1", rf_we32, rf_wd32, busy32, in_ready32);
    end
    $display("txn late response after reset ignored");
  endtask

  initial begin
    clk = 0;
    test_reset();
    test_nonload();
    test_load32();
    test_load64();
    test_flush();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
